// File: rtl/step_counter_pkg.sv
// Shared constants and helpers for the step_counter block.
package step_counter_pkg;

    // Direction select values for the dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Overflow handling select values for the sat input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Largest value representable in 'width' bits (2^width - 1), width in 1..32
    function automatic logic [31:0] max_val(input int width);
        logic [31:0] result;
        if (width >= 32) begin
            result = 32'hFFFF_FFFF;
        end else begin
            result = (32'd1 << width) - 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/step_counter_adder.sv
// Combinational WIDTH+1 bit add/subtract; the extra top bit is carry (add) or borrow (subtract).
module step_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   result
);

    // Zero-extend both operands so the MSB of the result captures carry or borrow
    always_comb begin
        if (sub) begin
            result = {1'b0, a} - {1'b0, b};
        end else begin
            result = {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/step_counter.sv
// Registered up/down counter with programmable step, load, and wrap/saturate overflow handling.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_val(WIDTH));

    logic [WIDTH:0]   adder_result;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             unf_next;

    step_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a      (count),
        .b      (step),
        .sub    (dir),
        .result (adder_result)
    );

    // Next-value selection: load beats enable, then carry/borrow drives wrap or clamp
    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = adder_result[WIDTH-1:0];
            if (adder_result[WIDTH]) begin
                if (dir == DIR_UP) begin
                    ovf_next = 1'b1;
                    if (sat == MODE_SAT) begin
                        count_next = MAX_COUNT;
                    end
                end else begin
                    unf_next = 1'b1;
                    if (sat == MODE_SAT) begin
                        count_next = '0;
                    end
                end
            end
        end
    end

    // State registers; reset has priority over everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
        end
    end

    // Terminal-value flags decoded straight from the registered count
    always_comb begin
        at_max = (count == MAX_COUNT);
        at_min = (count == '0);
    end

endmodule
